tpumac_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle systolic MAC cell. It forwards A/B operands to its neighbours with one-cycle latency. It multiplies through a configurable-depth product pipeline and accumulates into a local C register with MAC, MSUB or clear modes, optional saturation and a sticky overflow flag. It drops into the same systolic array slot as the existing cell and adds valid tagging so array controllers can tell when results are final.

---
 rtl/tpumac_pkg.sv | 43 ++++
 rtl/tpumac_mulpipe.sv | 62 ++++++
 rtl/tpumac_pipe.sv | 113 +++++++++++
 tb/tb_tpumac_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpumac_pkg.sv
// Shared types and the saturating-add helper for the pipelined systolic MAC cell.
// Sums are evaluated at a fixed wide width so one function serves any accumulator size.
package tpumac_pkg;

    typedef enum logic [1:0] {
        MODE_MAC   = 2'b00,
        MODE_MSUB  = 2'b01,
        MODE_CLEAR = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_t;

    // Widest accumulator the helper can serve; the sum carries one guard bit on top.
    localparam int SUM_MAX_W = 64;

    typedef struct packed {
        logic signed [SUM_MAX_W-1:0] value;
        logic                        ovf;
    } sat_t;

    // Range-check a sum against a bits_c-wide signed accumulator, clamping or wrapping.
    function automatic sat_t sat_add(input logic signed [SUM_MAX_W:0] sum,
                                     input int                        bits_c,
                                     input bit                        saturate);
        logic signed [SUM_MAX_W:0] one;
        logic signed [SUM_MAX_W:0] hi;
        logic signed [SUM_MAX_W:0] lo;
        sat_t                      res;
        one    = '0;
        one[0] = 1'b1;
        hi     = (one <<< (bits_c - 1)) - one;
        lo     = -(one <<< (bits_c - 1));
        res.ovf = (sum > hi) || (sum < lo);
        if (saturate && (sum > hi)) begin
            res.value = hi[SUM_MAX_W-1:0];
        end else if (saturate && (sum < lo)) begin
            res.value = lo[SUM_MAX_W-1:0];
        end else begin
            res.value = sum[SUM_MAX_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/tpumac_mulpipe.sv
// Product pipeline: STAGES-deep shift register of {valid, mode, product}.
// Holds completely while i_en is low; rst flushes the valid bits only.
module tpumac_mulpipe
    import tpumac_pkg::*;
#(
    parameter  int BITS_AB = 8,
    parameter  int STAGES  = 2,
    localparam int PROD_W  = 2 * BITS_AB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic                      i_valid,
    input  mode_t                     i_mode,
    input  logic signed [BITS_AB-1:0] i_a,
    input  logic signed [BITS_AB-1:0] i_b,
    output logic                      o_valid,
    output mode_t                     o_mode,
    output logic signed [PROD_W-1:0]  o_prod,
    output logic                      o_busy
);

    logic        [STAGES-1:0] r_valid;
    mode_t                    r_mode [STAGES];
    logic signed [PROD_W-1:0] r_prod [STAGES];

    logic signed [PROD_W-1:0] w_a_ext;
    logic signed [PROD_W-1:0] w_b_ext;

    assign w_a_ext = PROD_W'(i_a);
    assign w_b_ext = PROD_W'(i_b);

    // NOTE: sequential state uses <= so every stage samples its neighbour's pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_en) begin
            r_valid[0] <= i_valid;
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    // NOTE: payload is not reset; it is ignored whenever its valid bit is clear.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mode[0] <= i_mode;
            r_prod[0] <= w_a_ext * w_b_ext;
            for (int s = 1; s < STAGES; s++) begin
                r_mode[s] <= r_mode[s-1];
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    assign o_valid = r_valid[STAGES-1];
    assign o_mode  = r_mode[STAGES-1];
    assign o_prod  = r_prod[STAGES-1];
    assign o_busy  = |r_valid;

endmodule

// File: rtl/tpumac_pipe.sv
// Pipelined systolic MAC cell: one-cycle operand forwarding, MUL_STAGES product pipeline,
// accumulator with MAC/MSUB/CLEAR, optional saturation, sticky overflow and valid tagging.
module tpumac_pipe
    import tpumac_pkg::*;
#(
    parameter int BITS_AB    = 8,
    parameter int BITS_C     = 16,
    parameter int MUL_STAGES = 2,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic                      valid_in,
    input  logic [1:0]                mode,
    input  logic                      ovf_clr,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout,
    output logic                      valid_out,
    output logic                      busy,
    output logic                      ovf
);

    localparam int PROD_W = 2 * BITS_AB;
    localparam int EXT_W  = SUM_MAX_W + 1;

    if (BITS_C < 2 * BITS_AB) begin : g_chk_width
        $error("tpumac_pipe: BITS_C must be at least 2*BITS_AB");
    end
    if (BITS_C >= SUM_MAX_W) begin : g_chk_max
        $error("tpumac_pipe: BITS_C exceeds the saturation helper width");
    end
    if ((MUL_STAGES < 1) || (MUL_STAGES > 3)) begin : g_chk_stages
        $error("tpumac_pipe: MUL_STAGES must be 1..3");
    end

    logic                     w_ret_valid;
    mode_t                    w_ret_mode;
    logic signed [PROD_W-1:0] w_ret_prod;
    logic                     w_retire;
    logic signed [EXT_W-1:0]  w_acc_ext;
    logic signed [EXT_W-1:0]  w_prod_ext;
    logic signed [EXT_W-1:0]  w_sum_ext;
    sat_t                     w_sat;
    logic                     w_unused_hi;

    tpumac_mulpipe #(
        .BITS_AB (BITS_AB),
        .STAGES  (MUL_STAGES)
    ) u_mulpipe (
        .clk     (clk),
        .rst     (rst),
        .i_en    (en),
        .i_valid (valid_in),
        .i_mode  (mode_t'(mode)),
        .i_a     (Ain),
        .i_b     (Bin),
        .o_valid (w_ret_valid),
        .o_mode  (w_ret_mode),
        .o_prod  (w_ret_prod),
        .o_busy  (busy)
    );

    assign w_retire   = en & w_ret_valid;
    assign w_acc_ext  = {{(EXT_W - BITS_C){Cout[BITS_C-1]}}, Cout};
    assign w_prod_ext = {{(EXT_W - PROD_W){w_ret_prod[PROD_W-1]}}, w_ret_prod};

    // NOTE: default assignment first so no path through the case leaves w_sum_ext latched.
    always_comb begin
        w_sum_ext = w_acc_ext + w_prod_ext;
        case (w_ret_mode)
            MODE_MSUB:  w_sum_ext = w_acc_ext - w_prod_ext;
            MODE_CLEAR: w_sum_ext = '0;
            default:    w_sum_ext = w_acc_ext + w_prod_ext;
        endcase
    end

    assign w_sat       = sat_add(w_sum_ext, BITS_C, SATURATE);
    assign w_unused_hi = ^w_sat.value[SUM_MAX_W-1:BITS_C];

    always_ff @(posedge clk) begin
        if (rst) begin
            Aout      <= '0;
            Bout      <= '0;
            Cout      <= '0;
            valid_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (en) begin
                Aout <= Ain;
                Bout <= Bin;
            end
            // A preload wins over a retiring product, which is then dropped.
            valid_out <= w_retire & ~WrEn;
            if (WrEn) begin
                Cout <= Cin;
            end else if (w_retire) begin
                Cout <= w_sat.value[BITS_C-1:0];
            end
            if (w_retire && !WrEn && w_sat.ovf) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tpumac_pipe.sv
// Bench for tpumac_pipe: a saturating and a wrapping instance share stimulus and are
// compared each cycle against a queue-based model of issued operations and due times.
module tb_tpumac_pipe;

    localparam int BITS_AB    = 8;
    localparam int BITS_C     = 16;
    localparam int MUL_STAGES = 2;
    localparam longint C_HI   = (64'sd1 <<< (BITS_C - 1)) - 1;
    localparam longint C_LO   = -(64'sd1 <<< (BITS_C - 1));

    logic clk = 1'b0;
    logic rst, en, WrEn, valid_in, ovf_clr;
    logic [1:0] mode;
    logic signed [BITS_AB-1:0] Ain, Bin;
    logic signed [BITS_C-1:0]  Cin;

    logic signed [BITS_AB-1:0] aout_s, bout_s, aout_w, bout_w;
    logic signed [BITS_C-1:0]  cout_s, cout_w;
    logic vout_s, vout_w, busy_s, busy_w, ovf_s, ovf_w;

    int n_checks = 0;
    int n_fail   = 0;
    int n_vout   = 0;

    typedef struct {
        longint a;
        longint b;
        int     md;
        longint due;
    } op_t;

    op_t    q[$];
    longint en_tick = 0;
    longint m_c_sat = 0, m_c_wrap = 0, m_a = 0, m_b = 0;
    bit     m_ovf_sat = 0, m_ovf_wrap = 0, m_vout = 0;

    tpumac_pipe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .MUL_STAGES(MUL_STAGES), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .valid_in(valid_in), .mode(mode),
        .ovf_clr(ovf_clr), .Ain(Ain), .Bin(Bin), .Cin(Cin), .Aout(aout_s), .Bout(bout_s),
        .Cout(cout_s), .valid_out(vout_s), .busy(busy_s), .ovf(ovf_s)
    );

    tpumac_pipe #(.BITS_AB(BITS_AB), .BITS_C(BITS_C), .MUL_STAGES(MUL_STAGES), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .valid_in(valid_in), .mode(mode),
        .ovf_clr(ovf_clr), .Ain(Ain), .Bin(Bin), .Cin(Cin), .Aout(aout_w), .Bout(bout_w),
        .Cout(cout_w), .valid_out(vout_w), .busy(busy_w), .ovf(ovf_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint wrap_c(input longint s);
        longint m, r;
        m = 64'sd1 <<< BITS_C;
        r = (s - C_LO) % m;
        if (r < 0) r += m;
        return r + C_LO;
    endfunction

    // Accumulate one retired op into a model register under the given overflow policy.
    task automatic acc(input op_t op, input bit sat, inout longint c, output bit of);
        longint s;
        case (op.md)
            1:       s = c - op.a * op.b;
            2:       s = 0;
            default: s = c + op.a * op.b;
        endcase
        of = (s > C_HI) || (s < C_LO);
        if (!of)      c = s;
        else if (sat) c = (s > C_HI) ? C_HI : C_LO;
        else          c = wrap_c(s);
    endtask

    task automatic step(input bit i_en, input bit i_vin, input int i_md, input int a, input int b,
                        input bit i_wr = 0, input int i_cin = 0, input bit i_clr = 0,
                        input bit i_rst = 0);
        bit  ret, of_s, of_w;
        op_t r, n;
        en = i_en; valid_in = i_vin; mode = 2'(i_md); Ain = BITS_AB'(a); Bin = BITS_AB'(b);
        WrEn = i_wr; Cin = BITS_C'(i_cin); ovf_clr = i_clr; rst = i_rst;
        @(posedge clk);
        ret = 0; of_s = 0; of_w = 0;
        if (i_rst) begin
            q.delete();
            m_c_sat = 0; m_c_wrap = 0; m_a = 0; m_b = 0;
            m_ovf_sat = 0; m_ovf_wrap = 0; m_vout = 0;
        end else begin
            if (i_en) begin
                en_tick++;
                if (q.size() > 0 && q[0].due == en_tick) begin
                    ret = 1;
                    r = q.pop_front();
                end
                if (i_vin) begin
                    n.a = longint'(a); n.b = longint'(b); n.md = i_md; n.due = en_tick + MUL_STAGES;
                    q.push_back(n);
                end
                m_a = longint'(a); m_b = longint'(b);
            end
            m_vout = ret && !i_wr;
            if (i_wr) begin
                m_c_sat = longint'(i_cin); m_c_wrap = longint'(i_cin);
            end else if (ret) begin
                acc(r, 1'b1, m_c_sat, of_s);
                acc(r, 1'b0, m_c_wrap, of_w);
            end
            if (m_vout && of_s) m_ovf_sat = 1; else if (i_clr) m_ovf_sat = 0;
            if (m_vout && of_w) m_ovf_wrap = 1; else if (i_clr) m_ovf_wrap = 0;
        end
        #1;
        if (vout_s) n_vout++;
        check("cout_sat", cout_s, m_c_sat);
        check("cout_wrap", cout_w, m_c_wrap);
        check("valid_out", vout_s, longint'(m_vout));
        check("valid_out_w", vout_w, longint'(m_vout));
        check("busy", busy_s, longint'(q.size() > 0));
        check("ovf_sat", ovf_s, longint'(m_ovf_sat));
        check("ovf_wrap", ovf_w, longint'(m_ovf_wrap));
        check("aout", aout_s, m_a);
        check("bout", bout_s, m_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        int v0;
        rst = 1; en = 0; WrEn = 0; valid_in = 0; ovf_clr = 0; mode = 0; Ain = 0; Bin = 0; Cin = 0;

        // Reset and basic MAC stream
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_cout", cout_s, 0);
        check("rst_busy", busy_s, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 3, 4);
        step(1, 1, 0, -2, 5);
        step(1, 1, 0, 7, -1);
        check("stream_0", cout_s, 12);
        step(1, 0, 0, 0, 0);
        check("stream_1", cout_s, 2);
        step(1, 0, 0, 0, 0);
        check("stream_2", cout_s, -5);
        check("stream_busy_drop", busy_s, 0);
        idle(1);

        // Saturation / wrap, then ovf_clr colliding with a new overflow
        step(1, 0, 0, 0, 0, 1, 32000);
        step(1, 1, 0, 127, 127);
        idle(2);
        check("sat_clamp", cout_s, 32767);
        check("sat_ovf", ovf_s, 1);
        check("wrap_ovf", ovf_w, 1);
        step(1, 1, 0, 127, 127);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("ovf_set_wins", ovf_s, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        check("ovf_cleared", ovf_s, 0);

        // MSUB and CLEAR
        step(1, 0, 0, 0, 0, 1, 100);
        step(1, 1, 1, 10, 10);
        step(1, 1, 2, 55, 66);
        step(1, 0, 0, 0, 0);
        check("msub_zero", cout_s, 0);
        step(1, 0, 0, 0, 0);
        check("clear_zero", cout_s, 0);
        step(1, 0, 0, 0, 0, 1, 100);
        step(1, 1, 1, -128, -128);
        idle(2);
        check("msub_neg", cout_s, -16284);
        check("msub_no_ovf", ovf_s, 0);

        // Stall mid-flight
        step(1, 0, 0, 0, 0, 1, 0);
        v0 = n_vout;
        step(1, 1, 0, 5, 6);
        step(1, 1, 0, -3, 7);
        for (int i = 0; i < 3; i++) step(0, 1, 0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        check("stall_frozen", cout_s, 0);
        idle(3);
        check("stall_final", cout_s, 9);
        check("stall_retires", n_vout - v0, 2);

        // WrEn collides with a retire
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 2, 3);
        step(1, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 50);
        check("wren_coll", cout_s, 50);
        check("wren_coll_vout", vout_s, 0);
        step(1, 0, 0, 0, 0);
        check("wren_after", cout_s, 51);

        // Reset with products in flight
        step(1, 1, 0, 9, 9);
        step(1, 1, 0, 8, 8);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_mid_busy", busy_s, 0);
        check("rst_mid_cout", cout_s, 0);
        idle(3);
        check("rst_no_retire", cout_s, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3),
                 $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 65535) - 32768,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
